par_to_ser_gen: RTL and testbench
=================================

PAR_TO_SER_GEN -- requirements
Module: par_to_ser_gen

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits; legal range 2..32.
REQ-002 Parameter IDLE_WORD, default 8'hBC (WIDTH bits): filler word serialised when no data word is pending.
REQ-003 Parameter N_INIT, default 4: number of idle words sent after reset before data is accepted; legal range 1..255.
REQ-004 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.
REQ-005 clk32_f  input  1  bit-rate clock; the only clock; all state changes on its rising edge.
REQ-006 reset_L  input  1  reset; asynchronous assertion, active-low.
REQ-007 data_in  input  WIDTH  parallel word offered by the producer.
REQ-008 valid_in  input  1  data_in holds a word to transfer.
REQ-009 ready_out  output  1  block can take data_in on this edge.
REQ-010 data_out  output  1  serial bit stream.
REQ-011 sync_out  output  1  high during the first bit period of every word, idle or data.
REQ-012 valid_out  output  1  high for all WIDTH bit periods of a data word; low for idle words.
REQ-013 words_sent  output  16  count of data words serialised; saturates at 16'hFFFF.

Function
REQ-014 Internal state: shift register shreg[WIDTH], bit counter bit_cnt (clog2(WIDTH) bits), one-entry holding buffer buf/buf_full, init counter, state in {INIT, ACTIVE}.
REQ-015 A load edge is any rising edge with bit_cnt==0; on a load edge shreg takes the next word and bit_cnt becomes 1.
REQ-016 On a non-load edge shreg shifts one position toward the output end; bit_cnt increments and wraps from WIDTH-1 to 0.
REQ-017 data_out is shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0]; it is driven directly from the register with no combinational path from the inputs.
REQ-018 Next word: in INIT it is IDLE_WORD; in ACTIVE it is buf if buf_full, else IDLE_WORD.
REQ-019 sync_out and valid_out are registered on the load edge; sync_out clears on the following edge; valid_out holds for WIDTH cycles.
REQ-020 In INIT, each load edge decrements the init counter (preset to N_INIT); the load edge that consumes the last init word moves the state to ACTIVE.
REQ-021 ready_out = (state==ACTIVE) and (!buf_full or load edge consuming buf); it is 0 throughout INIT.
REQ-022 A transfer occurs on an edge with valid_in and ready_out both high; buf takes data_in and buf_full is set.
REQ-023 Simultaneous load and transfer: shreg takes the old buf and buf takes the new data_in; buf_full stays 1. There is no bypass from data_in to shreg.
REQ-024 Latency: a word accepted on edge E is loaded on the first load edge after E; its first bit appears on data_out in the cycle after that edge.
REQ-025 valid_in with ready_out low is ignored; data_in is not sampled and there is no error flag.
REQ-026 words_sent increments on each load edge that takes buf, and saturates at 16'hFFFF.
REQ-027 Back-to-back offers sustain one data word per WIDTH cycles with no idle words in between.

Reset
REQ-028 While reset_L=0: shreg=0, bit_cnt=0, buf=0, buf_full=0, init counter=N_INIT, state=INIT, data_out=0, sync_out=0, valid_out=0, ready_out=0, words_sent=0.
REQ-029 The first rising edge after reset_L rises is a load edge and loads IDLE_WORD.
REQ-030 Reset asserted mid-word aborts the word and any buffered word immediately; no partial word resumes after release.

Structure
REQ-031 A shared package holds the state encoding (INIT, ACTIVE), the default IDLE_WORD (8'hBC), and the words_sent width constant.
REQ-032 One sub-module, ser_shift_reg (load/shift register with bit counter and load-edge output), is instantiated once; the handshake, buffer and state machine live in par_to_ser_gen.

Verification (WIDTH=8, N_INIT=2, MSB_FIRST=1, IDLE_WORD=8'hBC)
REQ-033 Reset release with valid_in=0 -> data_out shows 10111100 repeated; sync_out pulses every 8 cycles; ready_out=0 for the first 16 cycles, then 1; valid_out=0 throughout.
REQ-034 Offer FF, AA, 25 back to back from the first ready_out -> serial 11111111 10101010 00100101 with valid_out high for 24 contiguous cycles, followed by BC idle words; words_sent=3.
REQ-035 Offer EE while buf_full and mid-word -> ready_out=0 and EE is held; EE is accepted on the next load edge and its bits follow the buffered word directly.
REQ-036 MSB_FIRST=0, offer 8'h01 -> bit 1 appears in the first bit period after sync_out, followed by seven 0s.
REQ-037 Assert reset_L=0 at bit 3 of data word AA -> all outputs are 0 immediately; after release, 2 idle words are sent, AA is not resent, and words_sent=0.
REQ-038 Force words_sent to 16'hFFFE, then send 3 words -> words_sent reads 16'hFFFF and holds.

Source files
------------

// File: rtl/par_to_ser_gen_pkg.sv
// Shared definitions for the parallel-to-serial generator: state encoding,
// default filler word and counter widths.
package par_to_ser_gen_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_INIT   = 1'b0;
  localparam state_t ST_ACTIVE = 1'b1;

  localparam logic [7:0] IDLE_WORD_DEF = 8'hBC;

  localparam int WORDS_W    = 16;
  localparam int INIT_CNT_W = 8;

endpackage

// File: rtl/par_to_ser_gen_shreg.sv
// Load/shift register with a bit counter. A load happens whenever the counter
// sits at zero; the serial bit is taken straight from the register.
module ser_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] word_i,
  output logic             load_o,
  output logic             ser_o
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  assign load_o = (bit_cnt_q == '0);

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (load_o) begin
      shreg_d   = word_i;
      bit_cnt_d = CNT_ONE;
    end else begin
      if (MSB_FIRST) begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      end
      bit_cnt_d = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Output end of the register depends on bit order.
  assign ser_o = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/par_to_ser_gen.sv
// Parallel-to-serial generator: one-entry holding buffer with ready/valid
// handshake, init idle sequence, word framing flags and a data-word counter.
module par_to_ser_gen
  import par_to_ser_gen_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(IDLE_WORD_DEF),
  parameter int               N_INIT    = 4,
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic               clk32_f,
  input  logic               reset_L,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               valid_in,
  output logic               ready_out,
  output logic               data_out,
  output logic               sync_out,
  output logic               valid_out,
  output logic [WORDS_W-1:0] words_sent
);

  localparam logic [INIT_CNT_W-1:0] INIT_PRESET = INIT_CNT_W'(N_INIT);

  state_t                state_q, state_d;
  logic [INIT_CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic [WIDTH-1:0]      hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  sync_q, sync_d;
  logic                  valid_q, valid_d;
  logic [WORDS_W-1:0]    words_q, words_d;

  logic             load;
  logic             active;
  logic             take_hold;
  logic             xfer;
  logic [WIDTH-1:0] next_word;

  function automatic logic [WORDS_W-1:0] sat_inc(input logic [WORDS_W-1:0] v);
    return (&v) ? v : v + WORDS_W'(1);
  endfunction

  assign active    = (state_q == ST_ACTIVE);
  assign take_hold = load & active & hold_full_q;
  assign ready_out = active & (~hold_full_q | take_hold);
  assign xfer      = valid_in & ready_out;
  // No bypass: the shifter only ever sees the held word or the filler.
  assign next_word = take_hold ? hold_q : IDLE_WORD;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sync_d      = load;
    valid_d     = valid_q;
    words_d     = words_q;

    // The load edge that ends the last init word opens the data path.
    if (load && !active) begin
      if (init_cnt_q == '0) begin
        state_d = ST_ACTIVE;
      end else begin
        init_cnt_d = init_cnt_q - INIT_CNT_W'(1);
      end
    end

    if (xfer) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end else if (take_hold) begin
      hold_full_d = 1'b0;
    end

    if (load) begin
      valid_d = take_hold;
    end

    if (take_hold) begin
      words_d = sat_inc(words_q);
    end
  end

  always_ff @(posedge clk32_f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= INIT_PRESET;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sync_q      <= 1'b0;
      valid_q     <= 1'b0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sync_q      <= sync_d;
      valid_q     <= valid_d;
      words_q     <= words_d;
    end
  end

  ser_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk_i  (clk32_f),
    .rst_ni (reset_L),
    .word_i (next_word),
    .load_o (load),
    .ser_o  (data_out)
  );

  assign sync_out   = sync_q;
  assign valid_out  = valid_q;
  assign words_sent = words_q;

endmodule

// File: tb/tb_par_to_ser_gen.sv
// Bench for par_to_ser_gen: word-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_par_to_ser_gen;

  localparam int         W    = 8;
  localparam logic [7:0] IDLE = 8'hBC;
  localparam int         NI   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_L = 1'b1;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        ready_out, data_out, sync_out, valid_out;
  logic [15:0] words_sent;

  logic [7:0]  data_in2;
  logic        valid_in2;
  logic        ready2, dout2, sync2, vld2;
  logic [15:0] ws2;

  int total = 0;
  int bad   = 0;

  par_to_ser_gen #(.WIDTH(W), .IDLE_WORD(IDLE), .N_INIT(NI), .MSB_FIRST(1'b1)) dut (
    .clk32_f(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .sync_out(sync_out),
    .valid_out(valid_out), .words_sent(words_sent));

  par_to_ser_gen #(.WIDTH(W), .IDLE_WORD(IDLE), .N_INIT(NI), .MSB_FIRST(1'b0)) dut_lsb (
    .clk32_f(clk), .reset_L(reset_L), .data_in(data_in2), .valid_in(valid_in2),
    .ready_out(ready2), .data_out(dout2), .sync_out(sync2),
    .valid_out(vld2), .words_sent(ws2));

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: the word currently on the line, which of its bit periods
  // is showing, the pending word, the idle words still owed and the data count.
  logic       m_started, m_active, m_valid, m_pend_full;
  int         m_phase, m_init_left, m_sent;
  int         m_base = 0;
  logic [7:0] m_word, m_pend;
  logic       m_load, m_ready, m_take;

  always_comb begin
    m_load  = !m_started || (m_phase == W - 1);
    m_ready = m_active && (!m_pend_full || m_load);
    m_take  = m_load && m_active && m_pend_full;
  end

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      m_started   <= 1'b0;
      m_active    <= 1'b0;
      m_valid     <= 1'b0;
      m_pend_full <= 1'b0;
      m_phase     <= 0;
      m_init_left <= NI;
      m_sent      <= 0;
      m_word      <= 8'h00;
      m_pend      <= 8'h00;
    end else begin
      if (m_load) begin
        m_word    <= m_take ? m_pend : IDLE;
        m_valid   <= m_take;
        m_phase   <= 0;
        m_started <= 1'b1;
        if (m_take) m_sent <= m_sent + 1;
        if (!m_active) begin
          if (m_init_left == 0) m_active <= 1'b1;
          else m_init_left <= m_init_left - 1;
        end
      end else begin
        m_phase <= m_phase + 1;
      end
      if (valid_in && m_ready) begin
        m_pend      <= data_in;
        m_pend_full <= 1'b1;
      end else if (m_take) begin
        m_pend_full <= 1'b0;
      end
    end
  end

  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("mdl_data_out", 32'(data_out), 32'(m_started ? m_word[W-1-m_phase] : 1'b0));
      check("mdl_sync_out", 32'(sync_out), 32'(m_started && m_phase == 0));
      check("mdl_valid_out", 32'(valid_out), 32'(m_started && m_valid));
      check("mdl_ready_out", 32'(ready_out), 32'(m_ready));
      check("mdl_words_sent", 32'(words_sent),
            ((m_base + m_sent) > 65535) ? 32'd65535 : 32'(m_base + m_sent));
    end
  end

  task automatic send_word(input logic [7:0] d);
    int guard;
    guard    = 0;
    data_in  = d;
    valid_in = 1'b1;
    while (!ready_out && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("send_ready_wait", 32'(guard < 40), 32'd1);
    @(negedge clk);
  endtask

  task automatic capture(input int nbits, output logic [31:0] bits, output int vcnt);
    int g;
    g    = 0;
    bits = '0;
    vcnt = 0;
    while (!(valid_out && sync_out) && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("capture_wait", 32'(g < 200), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      bits = {bits[30:0], data_out};
      if (valid_out) vcnt++;
      @(negedge clk);
    end
  endtask

  // LSB-first instance: a lone 8'h01 must show its 1 first.
  initial begin
    int         g2;
    logic [7:0] b;
    valid_in2 = 1'b1;
    data_in2  = 8'h01;
    @(posedge reset_L);
    g2 = 0;
    while (!(vld2 && sync2) && g2 < 100) begin
      @(negedge clk);
      g2++;
    end
    check("lsb_wait", 32'(g2 < 100), 32'd1);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b[i] = dout2;
      @(negedge clk);
    end
    check("lsb_first_bits", 32'(b), 32'h01);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cap;
    logic [15:0] cap16;
    int          vc, n_low, g, vhigh;
    logic        seen;

    data_in  = 8'h00;
    valid_in = 1'b0;
    #1 reset_L = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_sync_out", 32'(sync_out), 32'd0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_ready_out", 32'(ready_out), 32'd0);
    check("rst_words_sent", 32'(words_sent), 32'd0);

    // Idle stream after release; data path opens after two full idle words.
    #2 reset_L = 1'b1;
    n_low = 0;
    seen  = 1'b0;
    cap16 = '0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (i < 16) cap16 = {cap16[14:0], data_out};
      if (ready_out) seen = 1'b1;
      else n_low++;
    end
    check("ready_low_cycles", 32'(n_low), 32'd16);
    check("idle_pattern", 32'(cap16), 32'h0000BCBC);

    // Back-to-back words.
    fork
      begin
        send_word(8'hFF);
        send_word(8'hAA);
        send_word(8'h25);
        valid_in = 1'b0;
      end
      capture(24, cap, vc);
    join
    check("b2b_bits", 32'(cap[23:0]), 32'h00FFAA25);
    check("b2b_valid_cnt", 32'(vc), 32'd24);
    check("b2b_then_idle", 32'(valid_out), 32'd0);
    check("b2b_words_sent", 32'(words_sent), 32'd3);

    // Offer while the buffer is full in mid-word.
    g = 0;
    while (!sync_out && g < 20) begin
      @(negedge clk);
      g++;
    end
    data_in  = 8'h11;
    valid_in = 1'b1;
    @(negedge clk);
    data_in = 8'hEE;
    check("ready_while_full", 32'(ready_out), 32'd0);
    fork
      begin
        send_word(8'hEE);
        valid_in = 1'b0;
      end
      capture(16, cap, vc);
    join
    check("held_then_follow", 32'(cap[15:0]), 32'h000011EE);
    check("held_valid_cnt", 32'(vc), 32'd16);
    check("held_words_sent", 32'(words_sent), 32'd5);

    // Reset in the middle of data word AA.
    send_word(8'hAA);
    valid_in = 1'b0;
    g = 0;
    while (!(valid_out && sync_out) && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("aa_wait", 32'(g < 40), 32'd1);
    repeat (2) @(negedge clk);
    #2 reset_L = 1'b0;
    #1;
    check("midrst_data_out", 32'(data_out), 32'd0);
    check("midrst_sync_out", 32'(sync_out), 32'd0);
    check("midrst_valid_out", 32'(valid_out), 32'd0);
    check("midrst_ready_out", 32'(ready_out), 32'd0);
    check("midrst_words_sent", 32'(words_sent), 32'd0);
    repeat (2) @(negedge clk);
    #2 reset_L = 1'b1;
    vhigh = 0;
    cap16 = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 16) cap16 = {cap16[14:0], data_out};
      if (valid_out) vhigh++;
    end
    check("postrst_idle", 32'(cap16), 32'h0000BCBC);
    check("postrst_no_resend", 32'(vhigh), 32'd0);
    check("postrst_words_sent", 32'(words_sent), 32'd0);

    // Counter saturation.
    g = 0;
    while (!ready_out && g < 60) begin
      @(negedge clk);
      g++;
    end
    check("sat_ready_wait", 32'(g < 60), 32'd1);
    #2 force dut.words_q = 16'hFFFE;
    #1 release dut.words_q;
    m_base = 65534 - m_sent;
    @(negedge clk);
    check("sat_preset", 32'(words_sent), 32'h0000FFFE);
    send_word(8'h5A);
    send_word(8'hC3);
    send_word(8'h0F);
    valid_in = 1'b0;
    repeat (30) @(negedge clk);
    check("sat_reached", 32'(words_sent), 32'h0000FFFF);
    send_word(8'h77);
    valid_in = 1'b0;
    repeat (20) @(negedge clk);
    check("sat_holds", 32'(words_sent), 32'h0000FFFF);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
